// File: rtl/decode_queue_if.sv
// decode_queue_if: handshake bundle between fetch, the decode queue and issue.
//   in_valid/in_ready/in_pc/in_inst  : fetch side, queue input
//   out_valid/out_ready              : issue side handshake
//   pc_out/op/imm/en_*/reg_*/illegal : registered decoded micro-op
// slave  : the decode queue's view
// master : the fetch/issue environment's view
interface decode_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int OP_W   = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_pc;
   logic [INST_W-1:0] in_inst;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] pc_out;
   logic [OP_W-1:0]   op;
   logic [ADDR_W-1:0] imm;
   logic              en_rx;
   logic              en_ry;
   logic              en_w;
   logic [4:0]        reg_read_addrx;
   logic [4:0]        reg_read_addry;
   logic [4:0]        reg_write_addr;
   logic              illegal;

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, pc_out, op, imm, en_rx, en_ry, en_w,
             reg_read_addrx, reg_read_addry, reg_write_addr, illegal
   );

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, pc_out, op, imm, en_rx, en_ry, en_w,
             reg_read_addrx, reg_read_addry, reg_write_addr, illegal
   );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry (pc, inst) FIFO feeding a registered RV32I
// micro-op slot with valid/ready handshakes on both sides.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   rdy    : global enable; 0 freezes everything except reset and flush
//   flush  : empties the queue and invalidates the output slot
//   bus    : decode_queue_if.slave (fetch input + decoded micro-op output)
// Optional feature macro: DECODE_ILLEGAL_STALL_EN
//   defined   -> after issue accepts an illegal micro-op, loading halts until
//                flush or reset (pushes continue while not full)
//   undefined -> illegal ops are emitted as NOP with illegal=1, no halt
// op encodings: NOP=0 LUI=1 AUIPC=2 JAL=3 JALR=4 BRANCH=8+f3 LOAD=16+f3
//   STORE=24+f3 OPIMM=32+f3 OP=40+f3 SUB/SRA=48+f3 SRAI=61
module decode_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int OP_W   = 6
) (
   input logic           clk,
   input logic           rst_n,
   input logic           rdy,
   input logic           flush,
   decode_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [5:0] OP_NOP    = 6'd0;
   localparam logic [5:0] OP_LUI    = 6'd1;
   localparam logic [5:0] OP_AUIPC  = 6'd2;
   localparam logic [5:0] OP_JAL    = 6'd3;
   localparam logic [5:0] OP_JALR   = 6'd4;
   localparam logic [5:0] OP_BRANCH = 6'd8;
   localparam logic [5:0] OP_LOAD   = 6'd16;
   localparam logic [5:0] OP_STORE  = 6'd24;
   localparam logic [5:0] OP_OPIMM  = 6'd32;
   localparam logic [5:0] OP_OPREG  = 6'd40;
   localparam logic [5:0] OP_OPALT  = 6'd48;
   localparam logic [5:0] OP_SRAI   = 6'd61;

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [AW-1:0]     head_q, tail_q;
   logic [AW:0]       count_q;

   logic              out_valid_q, ill_q, en_rx_q, en_ry_q, en_w_q;
   logic [ADDR_W-1:0] pc_q, imm_q;
   logic [5:0]        op_q;
   logic [4:0]        ax_q, ay_q, aw_q;

   logic push, load, stall;
   logic [31:0] hi;
   logic [2:0]  f3;

   // decoded head
   logic              d_illegal, d_rx, d_ry, d_w;
   logic [5:0]        d_op;
   logic [ADDR_W-1:0] d_imm;
   logic [4:0]        d_ax, d_ay, d_aw;

   assign bus.in_ready = (count_q != (AW+1)'(DEPTH));
   assign push = bus.in_valid & bus.in_ready & rdy & ~flush;
   assign load = rdy & ~flush & (count_q != '0) & (~out_valid_q | bus.out_ready) & ~stall;

`ifdef DECODE_ILLEGAL_STALL_EN
   logic halted_q;
   // Accepting an illegal op also blocks the load on that same edge, so the
   // entry behind it is never emitted.
   assign stall = halted_q | (out_valid_q & bus.out_ready & ill_q);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halted_q <= 1'b0;
      else if (flush)
         halted_q <= 1'b0;
      else if (rdy & out_valid_q & bus.out_ready & ill_q)
         halted_q <= 1'b1;
   end
`else
   assign stall = 1'b0;
`endif

   assign hi = 32'(mem_inst[head_q]);
   assign f3 = hi[14:12];

   always_comb begin
      d_op = OP_NOP; d_imm = '0; d_illegal = 1'b0;
      d_rx = 1'b0; d_ry = 1'b0; d_w = 1'b0;
      d_ax = '0; d_ay = '0; d_aw = '0;
      case (hi[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            if (hi[6:0] == 7'b0010011)
               d_op = (f3 == 3'd5 && hi[30]) ? OP_SRAI : (OP_OPIMM | {3'b0, f3});
            else if (hi[6:0] == 7'b0000011)
               d_op = OP_LOAD | {3'b0, f3};
            else
               d_op = OP_JALR;
            d_imm = ADDR_W'($signed(hi[31:20]));
            d_rx = 1'b1; d_w = 1'b1; d_ax = hi[19:15]; d_aw = hi[11:7];
         end
         7'b0110011: begin
            d_op = (hi[30] && (f3 == 3'd0 || f3 == 3'd5)) ? (OP_OPALT | {3'b0, f3})
                                                          : (OP_OPREG | {3'b0, f3});
            d_rx = 1'b1; d_ry = 1'b1; d_w = 1'b1;
            d_ax = hi[19:15]; d_ay = hi[24:20]; d_aw = hi[11:7];
         end
         7'b0100011, 7'b1100011: begin
            if (hi[6:0] == 7'b0100011) begin
               d_op  = OP_STORE | {3'b0, f3};
               d_imm = ADDR_W'($signed({hi[31:25], hi[11:7]}));
            end else begin
               d_op  = OP_BRANCH | {3'b0, f3};
               d_imm = ADDR_W'($signed({hi[31], hi[7], hi[30:25], hi[11:8], 1'b0}));
            end
            d_rx = 1'b1; d_ry = 1'b1; d_ax = hi[19:15]; d_ay = hi[24:20];
         end
         7'b0110111, 7'b0010111: begin
            d_op  = (hi[5]) ? OP_LUI : OP_AUIPC;
            d_imm = ADDR_W'($signed({hi[31:12], 12'b0}));
            d_w = 1'b1; d_aw = hi[11:7];
         end
         7'b1101111: begin
            d_op  = OP_JAL;
            d_imm = ADDR_W'($signed({hi[31], hi[19:12], hi[20], hi[30:21], 1'b0}));
            d_w = 1'b1; d_aw = hi[11:7];
         end
         default: d_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[tail_q]   <= bus.in_pc;
         mem_inst[tail_q] <= bus.in_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0; tail_q <= '0; count_q <= '0;
      end else if (flush) begin
         head_q <= '0; tail_q <= '0; count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + AW'(1);
         if (load) head_q <= head_q + AW'(1);
         case ({push, load})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0; pc_q <= '0; op_q <= OP_NOP; imm_q <= '0;
         en_rx_q <= 1'b0; en_ry_q <= 1'b0; en_w_q <= 1'b0;
         ax_q <= '0; ay_q <= '0; aw_q <= '0; ill_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1; pc_q <= mem_pc[head_q]; op_q <= d_op; imm_q <= d_imm;
         en_rx_q <= d_rx; en_ry_q <= d_ry; en_w_q <= d_w;
         ax_q <= d_ax; ay_q <= d_ay; aw_q <= d_aw; ill_q <= d_illegal;
      end else if (rdy & out_valid_q & bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.pc_out         = pc_q;
   assign bus.op             = OP_W'(op_q);
   assign bus.imm            = imm_q;
   assign bus.en_rx          = en_rx_q;
   assign bus.en_ry          = en_ry_q;
   assign bus.en_w           = en_w_q;
   assign bus.reg_read_addrx = ax_q;
   assign bus.reg_read_addry = ay_q;
   assign bus.reg_write_addr = aw_q;
   assign bus.illegal        = ill_q;
endmodule
